bcd_time_counter: RTL and testbench

//  Free-running 24-hour time-of-day counter in packed BCD. Feeds hour24 directly into the decimal 24h->12h converter.

---
 rtl/bcd_time_counter.sv | 133 +++++++++++++
 tb/tb_bcd_time_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// bcd_time_counter
//   Free-running 24-hour time-of-day counter in packed BCD, with its own
//   1 Hz prescaler, a hold control and a validated time-set load port.
//
// Parameters
//   CLK_FREQ      input clock cycles per second (prescaler modulus)
//   USE_EXT_TICK  1: prescaler bypassed, advance once per ext_tick pulse
//
// Ports
//   clk        in   system clock, rising edge
//   nrst       in   synchronous active-low reset
//   ext_tick   in   one-cycle second strobe (USE_EXT_TICK=1 only)
//   hold       in   freeze time and prescaler
//   set_valid  in   one-cycle request to load set_hour/set_min/set_sec
//   set_hour   in   BCD hour   {tens[5:4], ones[3:0]}
//   set_min    in   BCD minute {tens[6:4], ones[3:0]}
//   set_sec    in   BCD second {tens[6:4], ones[3:0]}
//   set_ack    out  one-cycle pulse, load accepted
//   set_err    out  one-cycle pulse, load rejected
//   hour24     out  current hour,   BCD 0x00..0x23
//   minute     out  current minute, BCD 0x00..0x59
//   second     out  current second, BCD 0x00..0x59
//   sec_pulse  out  one-cycle pulse after the time advanced
//   day_pulse  out  one-cycle pulse on 23:59:59 -> 00:00:00
module bcd_time_counter #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter bit USE_EXT_TICK = 1'b0
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       ext_tick,
    input  logic       hold,
    input  logic       set_valid,
    input  logic [5:0] set_hour,
    input  logic [6:0] set_min,
    input  logic [6:0] set_sec,
    output logic       set_ack,
    output logic       set_err,
    output logic [5:0] hour24,
    output logic [6:0] minute,
    output logic [6:0] second,
    output logic       sec_pulse,
    output logic       day_pulse
);

    // A modulus of 1 still needs a 1-bit counter so the compare stays legal.
    localparam int            CW      = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_FREQ - 1);

    logic [CW-1:0] cnt;
    logic          presc_tick;
    logic          tick;
    logic          set_ok;
    logic          load;
    logic          sec_carry;
    logic          min_carry;
    logic          day_roll;
    logic [6:0]    sec_nxt;
    logic [6:0]    min_nxt;
    logic [5:0]    hour_nxt;

    always_comb begin
        presc_tick = (cnt == CNT_MAX) && !hold;
        tick       = USE_EXT_TICK ? (ext_tick & ~hold) : presc_tick;

        set_ok = (set_hour[3:0] <= 4'd9) && (set_hour <= 6'h23) &&
                 (set_min[3:0]  <= 4'd9) && (set_min[6:4] <= 3'd5) &&
                 (set_sec[3:0]  <= 4'd9) && (set_sec[6:4] <= 3'd5);
        load   = set_valid & set_ok;

        sec_carry = (second == 7'h59);
        min_carry = sec_carry && (minute == 7'h59);
        day_roll  = min_carry && (hour24 == 6'h23);

        if (second == 7'h59)
            sec_nxt = 7'h00;
        else if (second[3:0] == 4'd9)
            sec_nxt = {second[6:4] + 3'd1, 4'd0};
        else
            sec_nxt = {second[6:4], second[3:0] + 4'd1};

        if (minute == 7'h59)
            min_nxt = 7'h00;
        else if (minute[3:0] == 4'd9)
            min_nxt = {minute[6:4] + 3'd1, 4'd0};
        else
            min_nxt = {minute[6:4], minute[3:0] + 4'd1};

        // Ones wrap at 9 in the 0x and 1x decades; 0x23 is the only wrap in 2x.
        if (hour24 == 6'h23)
            hour_nxt = 6'h00;
        else if (hour24[3:0] == 4'd9)
            hour_nxt = {hour24[5:4] + 2'd1, 4'd0};
        else
            hour_nxt = {hour24[5:4], hour24[3:0] + 4'd1};
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt       <= '0;
            hour24    <= '0;
            minute    <= '0;
            second    <= '0;
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
        end else begin
            set_ack   <= load;
            set_err   <= set_valid & ~set_ok;
            // An accepted load swallows a coincident tick entirely.
            sec_pulse <= tick & ~load;
            day_pulse <= tick & ~load & day_roll;

            if (load) begin
                cnt    <= '0;
                hour24 <= set_hour;
                minute <= set_min;
                second <= set_sec;
            end else begin
                // In external-tick mode cnt is held at zero and drops out.
                if (!USE_EXT_TICK && !hold)
                    cnt <= presc_tick ? '0 : cnt + CW'(1);
                if (tick) begin
                    second <= sec_nxt;
                    if (sec_carry) minute <= min_nxt;
                    if (min_carry) hour24 <= hour_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
module tb_bcd_time_counter;

    logic       clk = 1'b0;
    logic       nrst;
    logic       ext_tick;
    logic       hold;
    logic       set_valid;
    logic [5:0] set_hour;
    logic [6:0] set_min;
    logic [6:0] set_sec;
    logic       set_ack;
    logic       set_err;
    logic [5:0] hour24;
    logic [6:0] minute;
    logic [6:0] second;
    logic       sec_pulse;
    logic       day_pulse;

    int checks   = 0;
    int failures = 0;

    bcd_time_counter #(.CLK_FREQ(4), .USE_EXT_TICK(1'b0)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .ext_tick  (ext_tick),
        .hold      (hold),
        .set_valid (set_valid),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .set_ack   (set_ack),
        .set_err   (set_err),
        .hour24    (hour24),
        .minute    (minute),
        .second    (second),
        .sec_pulse (sec_pulse),
        .day_pulse (day_pulse)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then sample at the following falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_time(input string tag, input logic [31:0] h,
                            input logic [31:0] m, input logic [31:0] s);
        chk({tag, ".hour"}, 32'(hour24), h);
        chk({tag, ".min"},  32'(minute), m);
        chk({tag, ".sec"},  32'(second), s);
    endtask

    task automatic chk_pulses(input string tag, input logic sp, input logic dp,
                              input logic ack, input logic err);
        chk({tag, ".sec_pulse"}, 32'(sec_pulse), 32'(sp));
        chk({tag, ".day_pulse"}, 32'(day_pulse), 32'(dp));
        chk({tag, ".set_ack"},   32'(set_ack),   32'(ack));
        chk({tag, ".set_err"},   32'(set_err),   32'(err));
    endtask

    // Drive one set_valid cycle; returns sampled after the load edge.
    task automatic do_set(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s);
        set_valid = 1'b1;
        set_hour  = h;
        set_min   = m;
        set_sec   = s;
        step(1);
        set_valid = 1'b0;
    endtask

    initial begin
        nrst      = 1'b0;
        ext_tick  = 1'b0;
        hold      = 1'b0;
        set_valid = 1'b0;
        set_hour  = '0;
        set_min   = '0;
        set_sec   = '0;
        step(2);
        chk_time("reset", 'h00, 'h00, 'h00);
        chk_pulses("reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // 1: free run, tick on every 4th edge
        nrst = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            chk($sformatf("run.c%0d.sec_pulse", i), 32'(sec_pulse), 32'((i % 4) == 0));
        end
        chk_time("run12", 'h00, 'h00, 'h03);

        // 2: day rollover
        do_set(6'h23, 7'h59, 7'h59);
        chk_time("set235959", 'h23, 'h59, 'h59);
        chk_pulses("set235959", 1'b0, 1'b0, 1'b1, 1'b0);
        step(1);
        chk("set235959.ack_clear", 32'(set_ack), 'h0);
        step(2);
        chk_time("pre_roll", 'h23, 'h59, 'h59);
        step(1);
        chk_time("day_roll", 'h00, 'h00, 'h00);
        chk_pulses("day_roll", 1'b1, 1'b1, 1'b0, 1'b0);
        step(1);
        chk_pulses("day_roll_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: decade carries in the hour field and a plain minute carry
        do_set(6'h09, 7'h59, 7'h59);
        step(4);
        chk_time("to10", 'h10, 'h00, 'h00);
        chk_pulses("to10", 1'b1, 1'b0, 1'b0, 1'b0);
        do_set(6'h12, 7'h34, 7'h59);
        step(4);
        chk_time("min_carry", 'h12, 'h35, 'h00);
        do_set(6'h19, 7'h59, 7'h59);
        step(4);
        chk_time("to20", 'h20, 'h00, 'h00);
        chk_pulses("to20", 1'b1, 1'b0, 1'b0, 1'b0);

        // 4: rejected sets, prescaler keeps running (cnt 0,1,2 here)
        do_set(6'h24, 7'h00, 7'h00);
        chk_time("bad_hour", 'h20, 'h00, 'h00);
        chk_pulses("bad_hour", 1'b0, 1'b0, 1'b0, 1'b1);
        do_set(6'h12, 7'h60, 7'h00);
        chk_time("bad_min_tens", 'h20, 'h00, 'h00);
        chk_pulses("bad_min_tens", 1'b0, 1'b0, 1'b0, 1'b1);
        do_set(6'h12, 7'h1A, 7'h00);
        chk_time("bad_min_ones", 'h20, 'h00, 'h00);
        chk_pulses("bad_min_ones", 1'b0, 1'b0, 1'b0, 1'b1);
        step(1);
        chk_time("after_bad", 'h20, 'h00, 'h01);
        chk_pulses("after_bad", 1'b1, 1'b0, 1'b0, 1'b0);

        // 5: set coincident with tick (cnt==3 during the set cycle)
        step(3);
        chk_time("pre_coinc", 'h20, 'h00, 'h01);
        do_set(6'h05, 7'h00, 7'h00);
        chk_time("coinc", 'h05, 'h00, 'h00);
        chk_pulses("coinc", 1'b0, 1'b0, 1'b1, 1'b0);
        step(3);
        chk_time("coinc_wait", 'h05, 'h00, 'h00);
        step(1);
        chk_time("coinc_next", 'h05, 'h00, 'h01);
        chk("coinc_next.sec_pulse", 32'(sec_pulse), 'h1);

        // 6: hold with prescaler at 2, then resume from 2
        step(2);
        hold = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            chk($sformatf("hold.c%0d.sec_pulse", i), 32'(sec_pulse), 'h0);
        end
        chk_time("hold", 'h05, 'h00, 'h01);
        hold = 1'b0;
        step(1);
        chk_time("resume1", 'h05, 'h00, 'h01);
        step(1);
        chk_time("resume2", 'h05, 'h00, 'h02);
        chk("resume2.sec_pulse", 32'(sec_pulse), 'h1);

        // set during hold is accepted and restarts the prescaler
        hold = 1'b1;
        do_set(6'h07, 7'h30, 7'h00);
        chk_time("hold_set", 'h07, 'h30, 'h00);
        chk("hold_set.ack", 32'(set_ack), 'h1);
        step(5);
        chk_time("hold_set_wait", 'h07, 'h30, 'h00);
        hold = 1'b0;
        step(3);
        chk_time("hold_set_pre", 'h07, 'h30, 'h00);
        step(1);
        chk_time("hold_set_tick", 'h07, 'h30, 'h01);

        // reset mid-run overrides a simultaneous set
        step(2);
        nrst = 1'b0;
        do_set(6'h11, 7'h11, 7'h11);
        chk_time("mid_reset", 'h00, 'h00, 'h00);
        chk_pulses("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        nrst = 1'b1;
        step(3);
        chk_time("post_reset_wait", 'h00, 'h00, 'h00);
        step(1);
        chk_time("post_reset_tick", 'h00, 'h00, 'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
